// File: rtl/table_divider.sv
// rtl/table_divider.sv - sequential divider walking the divisor's multiplication table
module table_divider #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WALK = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] dividend_r;
    logic [W-1:0] divisor_r;
    logic [W-1:0] q;
    logic [W:0]   prod;
    logic [W:0]   next_prod;
    logic         step_ok;

    // prod never exceeds dividend_r, so the extra bit absorbs the one extra row
    assign next_prod = prod + {1'b0, divisor_r};
    assign step_ok   = (next_prod <= {1'b0, dividend_r});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dividend_r  <= '0;
            divisor_r   <= '0;
            q           <= '0;
            prod        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        q          <= '0;
                        prod       <= '0;
                        busy       <= 1'b1;
                        state      <= WALK;
                    end
                end
                WALK: begin
                    if (divisor_r == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend_r;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (step_ok) begin
                        q    <= q + 1'b1;
                        prod <= next_prod;
                    end else begin
                        quotient    <= q;
                        remainder   <= dividend_r - prod[W-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_table_divider.sv
// tb/tb_table_divider.sv - directed self-checking bench for table_divider
module tb_table_divider;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int lat;
    int busy_cnt;
    logic seen_done;

    table_divider #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives start for one edge (E0), leaving time at E0+1ns
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 10'h155;
        divisor  = 10'h0aa;
    endtask

    // Counts edges after E0 until done; optional stray start injected at cycle inject
    task automatic wait_done(input int inject, output int l, output int bc);
        l  = 0;
        bc = busy ? 1 : 0;
        while (!done && l < 1100) begin
            if (l == inject) begin
                dividend = 10'd100;
                divisor  = 10'd3;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            l++;
            if (busy) bc++;
        end
    endtask

    initial begin
        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = i[0];
            dividend = 10'(i * 37 + 5);
            divisor  = 10'(i + 1);
        end
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quot", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;

        // 17/5
        issue(10'd17, 10'd5);
        check("17_5_busy_e0", 32'(busy), 1);
        wait_done(-1, lat, busy_cnt);
        check("17_5_lat", 32'(lat), 4);
        check("17_5_quot", 32'(quotient), 3);
        check("17_5_rem", 32'(remainder), 2);
        check("17_5_dbz", 32'(div_by_zero), 0);
        check("17_5_busycnt", 32'(busy_cnt), 4);
        @(posedge clk);
        #1;
        check("17_5_done_drop", 32'(done), 0);
        check("17_5_quot_hold", 32'(quotient), 3);

        // 10/2 exact
        issue(10'd10, 10'd2);
        wait_done(-1, lat, busy_cnt);
        check("10_2_lat", 32'(lat), 6);
        check("10_2_quot", 32'(quotient), 5);
        check("10_2_rem", 32'(remainder), 0);

        // 3/7 small dividend
        issue(10'd3, 10'd7);
        wait_done(-1, lat, busy_cnt);
        check("3_7_lat", 32'(lat), 1);
        check("3_7_quot", 32'(quotient), 0);
        check("3_7_rem", 32'(remainder), 3);

        // 1023/1 width limit
        issue(10'd1023, 10'd1);
        wait_done(-1, lat, busy_cnt);
        check("1023_1_lat", 32'(lat), 1024);
        check("1023_1_quot", 32'(quotient), 1023);
        check("1023_1_rem", 32'(remainder), 0);
        check("1023_1_busycnt", 32'(busy_cnt), 1024);

        // 5/0 then 9/4
        issue(10'd5, 10'd0);
        wait_done(-1, lat, busy_cnt);
        check("5_0_lat", 32'(lat), 1);
        check("5_0_dbz", 32'(div_by_zero), 1);
        check("5_0_quot", 32'(quotient), 1023);
        check("5_0_rem", 32'(remainder), 5);
        issue(10'd9, 10'd4);
        wait_done(-1, lat, busy_cnt);
        check("9_4_dbz", 32'(div_by_zero), 0);
        check("9_4_quot", 32'(quotient), 2);
        check("9_4_rem", 32'(remainder), 1);
        check("9_4_lat", 32'(lat), 3);

        // 50/7 with stray start mid-walk
        issue(10'd50, 10'd7);
        wait_done(2, lat, busy_cnt);
        check("50_7_lat", 32'(lat), 8);
        check("50_7_quot", 32'(quotient), 7);
        check("50_7_rem", 32'(remainder), 1);

        // start during done cycle: 8/8
        dividend = 10'd8;
        divisor  = 10'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done", 32'(done), 0);
        wait_done(-1, lat, busy_cnt);
        check("8_8_lat", 32'(lat), 2);
        check("8_8_quot", 32'(quotient), 1);
        check("8_8_rem", 32'(remainder), 0);

        // reset mid-walk of 200/1 at E0+3
        issue(10'd200, 10'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quot", 32'(quotient), 0);
        @(negedge clk);
        rst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 0);

        issue(10'd6, 10'd4);
        wait_done(-1, lat, busy_cnt);
        check("6_4_lat", 32'(lat), 2);
        check("6_4_quot", 32'(quotient), 1);
        check("6_4_rem", 32'(remainder), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/table_divider.md
# table_divider

Sequential integer divider that computes a quotient by stepping through the multiplication table of the divisor. It accumulates divisor, 2·divisor, 3·divisor, … one row per clock until the next row would exceed the dividend, then reports the quotient and remainder. It sits downstream of the table generators and recovers the multiplier from a product. Control is a start/busy/done handshake.

## Interface
- W, default 10: operand and result width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: 0 resets the block immediately, 1 releases it.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  unsigned numerator; captured on the accepted start.
- divisor  input  W  unsigned denominator; captured on the accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle completion pulse.
- quotient  output  W  result; holds until the next completion.
- remainder  output  W  result; holds until the next completion.
- div_by_zero  output  1  error flag for the last completed operation; holds until the next completion.

## Operation
- Internal registers:
  - dividend_r and divisor_r (W bits).
  - row count q (W bits).
  - running product prod (W+1 bits). prod = divisor_r·q at all times, so prod+divisor_r never overflows.
- States: IDLE and WALK.
- IDLE:
  - On start=1, capture the operands, clear q and prod, set busy=1, and go to WALK.
  - With start=0, stay in IDLE.
- WALK, one decision per cycle, in priority order:
  - divisor_r==0: finish with quotient={W{1}}, remainder=dividend_r, div_by_zero=1.
  - prod+divisor_r ≤ dividend_r: q←q+1, prod←prod+divisor_r, stay in WALK.
  - Otherwise: finish with quotient=q, remainder=dividend_r−prod[W-1:0], div_by_zero=0.
- Finish (at the same edge):
  - Register the results and set done=1.
  - Clear busy and return to IDLE.
- done is cleared at the following edge unconditionally.
- start while busy=1 is ignored. The captured operands do not change mid-walk.
- start=1 in the cycle where done=1 is accepted, because the state is already IDLE. done drops and busy rises at that edge.
- Invariant on every normal completion: quotient·divisor + remainder = dividend, with remainder < divisor.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - q, prod and the captured operands are cleared.
- Reset asserted mid-walk aborts the operation. No done pulse is produced.
- Let start be accepted at edge E0, and let Q be the reported quotient:
  - busy=1 from E0 until edge E0+Q+1.
  - done=1 for exactly the cycle after E0+Q+1. quotient, remainder and div_by_zero are valid from that same edge.
  - Latency is Q+1 cycles; the worst case is 2^W cycles (dividend=2^W−1, divisor=1).
- Divide-by-zero completes at E0+1 (latency 1).
- Dividend < divisor completes at E0+1 with Q=0.
- Back-to-back throughput: one new start per Q+2 cycles, counting the start issued during the done cycle.

## Test plan
- Reset value, then simple division:
  - Hold rst=0 with inputs toggling → all outputs 0.
  - Release rst, then start with 17/5 → done at E0+4, quotient=3, remainder=2, div_by_zero=0, busy high for exactly 4 cycles.
- Exact division and small dividend:
  - 10/2 → quotient=5, remainder=0, done at E0+6.
  - 3/7 → quotient=0, remainder=3, done at E0+1.
- Width limit: 1023/1 → quotient=1023, remainder=0, done at E0+1024, no overflow wrap.
- Divide by zero: 5/0 → done at E0+1, div_by_zero=1, quotient=1023, remainder=5. A following 9/4 → div_by_zero=0, quotient=2, remainder=1.
- Handshake:
  - Pulse start with 100/3 while busy on 50/7 → ignored; 50/7 result is 7 r 1.
  - Assert start during the done cycle with 8/8 → accepted, and quotient=1, remainder=0 two cycles later.
- Reset mid-operation:
  - Drop rst at E0+3 of 200/1 → busy=0 and done=0 immediately; no done pulse follows.
  - A subsequent 6/4 → quotient=1, remainder=2.
